// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order FIFO of translated stores, drained to the
// data cache once the ROB grants commit, with combinational store-to-load forwarding.
module store_buffer #(
    parameter int N                = 4,
    parameter int WORD_SIZE        = 32,
    parameter int WIDTH            = 32,
    parameter int ROB_ENTRY_WIDTH  = 3,
    parameter int SIZE_WRITE_WIDTH = 2,
    parameter int INIT             = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_SIZE-1:0]        store_value,
    input  logic [WIDTH-1:0]            physical_address,
    input  logic [ROB_ENTRY_WIDTH-1:0]  input_rob_id,
    input  logic [SIZE_WRITE_WIDTH-1:0] op_size,
    input  logic                        store,
    input  logic                        TLBexception,
    input  logic                        store_permission,
    input  logic [ROB_ENTRY_WIDTH-1:0]  store_permission_rob_id,
    input  logic                        store_success,
    output logic [WORD_SIZE-1:0]        cache_store_value,
    output logic [WIDTH-1:0]            cache_physical_address,
    output logic                        cache_wenable,
    output logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
    output logic                        full,
    output logic [WORD_SIZE-1:0]        bypass_value,
    output logic                        bypass_needed,
    output logic                        bypass_possible
);

    localparam int AW = $clog2(N);
    localparam logic [AW:0] N_ENTRIES = (AW+1)'(N);

    logic [AW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [AW:0]                 entries_q, entries_d;
    logic [WORD_SIZE-1:0]        value_q [N];
    logic [WORD_SIZE-1:0]        value_d [N];
    logic [WIDTH-1:0]            addr_q [N];
    logic [WIDTH-1:0]            addr_d [N];
    logic [SIZE_WRITE_WIDTH-1:0] size_q [N];
    logic [SIZE_WRITE_WIDTH-1:0] size_d [N];
    logic [ROB_ENTRY_WIDTH-1:0]  rob_id_q [N];
    logic [ROB_ENTRY_WIDTH-1:0]  rob_id_d [N];
    logic [N-1:0]                can_store_q, can_store_d;
    logic [N-1:0]                valid_q, valid_d;

    // Architectural names of the buffer state; all logic below reads these.
    logic [AW-1:0]               head, tail;
    logic [AW:0]                 entries;
    logic [WORD_SIZE-1:0]        value [N];
    logic [WIDTH-1:0]            physical_addresses [N];
    logic [SIZE_WRITE_WIDTH-1:0] size [N];
    logic [ROB_ENTRY_WIDTH-1:0]  rob_id [N];
    logic [N-1:0]                can_store, valid;

    assign head               = head_q;
    assign tail               = tail_q;
    assign entries            = entries_q;
    assign value              = value_q;
    assign physical_addresses = addr_q;
    assign size               = size_q;
    assign rob_id             = rob_id_q;
    assign can_store          = can_store_q;
    assign valid              = valid_q;

    // Size code to bit count; unused code 3 is treated as a full word.
    function automatic int size_bits(input logic [SIZE_WRITE_WIDTH-1:0] code);
        if (code == SIZE_WRITE_WIDTH'(0))      return 8;
        else if (code == SIZE_WRITE_WIDTH'(1)) return 16;
        else                                   return 32;
    endfunction

    function automatic logic [WIDTH:0] size_bytes(input logic [SIZE_WRITE_WIDTH-1:0] code);
        return (WIDTH+1)'(size_bits(code) / 8);
    endfunction

    logic            alloc, pop;
    logic [WIDTH:0]  ld_lo, ld_end;
    logic [N-1:0]    overlap, contain, perm_match;

    assign full          = (entries == N_ENTRIES);
    assign alloc         = store && !TLBexception && !full;
    assign cache_wenable = valid[head] && can_store[head];
    assign pop           = store_success && cache_wenable;

    assign cache_store_value      = cache_wenable ? value[head]              : '0;
    assign cache_physical_address = cache_wenable ? physical_addresses[head] : '0;
    assign cache_store_size       = cache_wenable ? size[head]               : '0;

    // Ranges use one extra bit so a range ending at the top of memory does not wrap.
    assign ld_lo  = {1'b0, physical_address};
    assign ld_end = ld_lo + size_bytes(op_size);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_entry
            logic [WIDTH:0] st_lo, st_end;
            assign st_lo          = {1'b0, physical_addresses[gi]};
            assign st_end         = st_lo + size_bytes(size[gi]);
            assign overlap[gi]    = valid[gi] && (st_lo < ld_end) && (ld_lo < st_end);
            assign contain[gi]    = (st_lo <= ld_lo) && (ld_end <= st_end);
            assign perm_match[gi] = valid[gi] && !can_store[gi] &&
                                    (rob_id[gi] == store_permission_rob_id);
        end
    endgenerate

    // Scan oldest to youngest: last overlap wins forwarding, first match wins the grant.
    logic          fwd_found, perm_found;
    logic [AW-1:0] fwd_idx, perm_idx, scan_idx;

    always_comb begin
        fwd_found  = 1'b0;
        fwd_idx    = '0;
        perm_found = 1'b0;
        perm_idx   = '0;
        scan_idx   = head;
        for (int i = 0; i < N; i++) begin
            scan_idx = head + AW'(i);
            if (overlap[scan_idx]) begin
                fwd_found = 1'b1;
                fwd_idx   = scan_idx;
            end
            if (!perm_found && perm_match[scan_idx]) begin
                perm_found = 1'b1;
                perm_idx   = scan_idx;
            end
        end
    end

    logic [WORD_SIZE-1:0] fwd_mask;
    logic [WIDTH-1:0]     fwd_shift;

    always_comb begin
        fwd_mask = '1;
        if (size_bits(op_size) < WORD_SIZE)
            fwd_mask = ~({WORD_SIZE{1'b1}} << size_bits(op_size));
        fwd_shift       = (physical_address - physical_addresses[fwd_idx]) << 3;
        bypass_needed   = fwd_found;
        bypass_possible = fwd_found && contain[fwd_idx];
        bypass_value    = '0;
        if (bypass_possible)
            bypass_value = (value[fwd_idx] >> fwd_shift) & fwd_mask;
    end

    always_comb begin
        head_d      = head;
        tail_d      = tail;
        entries_d   = entries;
        value_d     = value;
        addr_d      = physical_addresses;
        size_d      = size;
        rob_id_d    = rob_id;
        can_store_d = can_store;
        valid_d     = valid;

        if (store_permission && perm_found)
            can_store_d[perm_idx] = 1'b1;

        if (pop) begin
            valid_d[head]     = 1'b0;
            can_store_d[head] = 1'b0;
            head_d            = head + AW'(1);
        end

        if (alloc) begin
            value_d[tail]     = store_value;
            addr_d[tail]      = physical_address;
            size_d[tail]      = op_size;
            rob_id_d[tail]    = input_rob_id;
            valid_d[tail]     = 1'b1;
            can_store_d[tail] = 1'b0;
            tail_d            = tail + AW'(1);
        end

        case ({alloc, pop})
            2'b10:   entries_d = entries + (AW+1)'(1);
            2'b01:   entries_d = entries - (AW+1)'(1);
            default: entries_d = entries;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            entries_q   <= '0;
            can_store_q <= '0;
            valid_q     <= '0;
            for (int i = 0; i < N; i++) begin
                value_q[i]  <= WORD_SIZE'(INIT);
                addr_q[i]   <= WIDTH'(INIT);
                size_q[i]   <= '0;
                rob_id_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            entries_q   <= entries_d;
            can_store_q <= can_store_d;
            valid_q     <= valid_d;
            value_q     <= value_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            rob_id_q    <= rob_id_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected values are queued as stimulus is
// driven and compared with immediate assertions when the outputs are sampled.
module tb_store_buffer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] store_value;
    logic [31:0] physical_address;
    logic [2:0]  input_rob_id;
    logic [1:0]  op_size;
    logic        store;
    logic        TLBexception;
    logic        store_permission;
    logic [2:0]  store_permission_rob_id;
    logic        store_success;
    logic [31:0] cache_store_value;
    logic [31:0] cache_physical_address;
    logic        cache_wenable;
    logic [1:0]  cache_store_size;
    logic        full;
    logic [31:0] bypass_value;
    logic        bypass_needed;
    logic        bypass_possible;

    store_buffer #(
        .N(N), .WORD_SIZE(32), .WIDTH(32), .ROB_ENTRY_WIDTH(3),
        .SIZE_WRITE_WIDTH(2), .INIT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .store_value(store_value), .physical_address(physical_address),
        .input_rob_id(input_rob_id), .op_size(op_size),
        .store(store), .TLBexception(TLBexception),
        .store_permission(store_permission),
        .store_permission_rob_id(store_permission_rob_id),
        .store_success(store_success),
        .cache_store_value(cache_store_value),
        .cache_physical_address(cache_physical_address),
        .cache_wenable(cache_wenable), .cache_store_size(cache_store_size),
        .full(full), .bypass_value(bypass_value),
        .bypass_needed(bypass_needed), .bypass_possible(bypass_possible)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   passes = 0;
    int   fails  = 0;
    int   total  = 0;

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t x;
        total++;
        if (sbq.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_underflow observed=%0h required=<queued value>", obs);
            return;
        end
        x = sbq.pop_front();
        assert (obs === x.exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h required=%0h", x.tag, obs, x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] v, input logic [31:0] a,
                               input logic [2:0] rob, input logic [1:0] sz);
        store            = 1'b1;
        store_value      = v;
        physical_address = a;
        input_rob_id     = rob;
        op_size          = sz;
    endtask

    task automatic probe(input string nm, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] ev, input logic en, input logic ep);
        physical_address = a;
        op_size          = sz;
        push({nm, "_value"}, ev);
        push({nm, "_needed"}, {31'b0, en});
        push({nm, "_possible"}, {31'b0, ep});
        @(negedge clk);
        pop_check(bypass_value);
        pop_check({31'b0, bypass_needed});
        pop_check({31'b0, bypass_possible});
        $display("probe %s addr=%0d size=%0d value=%0h needed=%0b possible=%0b",
                 nm, a, sz, bypass_value, bypass_needed, bypass_possible);
    endtask

    initial begin
        rst = 1'b1; store = 1'b0; TLBexception = 1'b0; store_permission = 1'b0;
        store_permission_rob_id = '0; store_success = 1'b0; store_value = '0;
        physical_address = '0; input_rob_id = '0; op_size = '0;
        tick();
        tick();
        rst = 1'b0;

        push("rst_full", 0); push("rst_wenable", 0); push("rst_cache_value", 0);
        push("rst_cache_addr", 0); push("rst_bypass_needed", 0); push("rst_entries", 0);
        @(negedge clk);
        pop_check({31'b0, full}); pop_check({31'b0, cache_wenable});
        pop_check(cache_store_value); pop_check(cache_physical_address);
        pop_check({31'b0, bypass_needed}); pop_check({29'b0, dut.entries});
        $display("reset: entries=%0d full=%0b", dut.entries, full);

        drive_store(32'd26, 32'd4, 3'd0, 2'd2);          tick();
        drive_store(32'd2, 32'd8, 3'd2, 2'd0);           tick();
        drive_store(32'h03020100, 32'd12, 3'd0, 2'd2);   tick();
        store = 1'b0;
        push("alloc_entries", 3); push("alloc_value0", 26); push("alloc_addr0", 4);
        push("alloc_size0", 2); push("alloc_can_store0", 0); push("alloc_valid2", 1);
        push("alloc_tail", 3);
        @(negedge clk);
        pop_check({29'b0, dut.entries}); pop_check(dut.value[0]);
        pop_check(dut.physical_addresses[0]); pop_check({30'b0, dut.size[0]});
        pop_check({31'b0, dut.can_store[0]}); pop_check({31'b0, dut.valid[2]});
        pop_check({30'b0, dut.tail});
        $display("alloc x3: entries=%0d tail=%0d", dut.entries, dut.tail);

        probe("lw4", 32'd4, 2'd2, 32'd26, 1'b1, 1'b1);
        probe("lw8", 32'd8, 2'd2, 32'd0, 1'b1, 1'b0);
        probe("lw48", 32'd48, 2'd2, 32'd0, 1'b0, 1'b0);
        probe("lb8", 32'd8, 2'd0, 32'd2, 1'b1, 1'b1);
        probe("lb9", 32'd9, 2'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            probe($sformatf("lb%0d", 12 + i), 32'(12 + i), 2'd0, 32'(i), 1'b1, 1'b1);
        probe("lh14", 32'd14, 2'd1, 32'h0302, 1'b1, 1'b1);
        probe("lw6", 32'd6, 2'd2, 32'd0, 1'b1, 1'b0);

        store_permission = 1'b1; store_permission_rob_id = 3'd0;
        tick();
        store_permission = 1'b0;
        push("grant_can_store0", 1); push("grant_can_store2", 0); push("grant_wenable", 1);
        push("grant_cache_value", 26); push("grant_cache_addr", 4); push("grant_cache_size", 2);
        @(negedge clk);
        pop_check({31'b0, dut.can_store[0]}); pop_check({31'b0, dut.can_store[2]});
        pop_check({31'b0, cache_wenable}); pop_check(cache_store_value);
        pop_check(cache_physical_address); pop_check({30'b0, cache_store_size});
        $display("grant rob0: wenable=%0b value=%0d addr=%0d", cache_wenable,
                 cache_store_value, cache_physical_address);

        store_permission = 1'b1; store_permission_rob_id = 3'd0;
        tick();
        store_permission = 1'b0;
        push("grant2_can_store2", 1);
        @(negedge clk);
        pop_check({31'b0, dut.can_store[2]});
        $display("grant rob0 again: can_store[2]=%0b", dut.can_store[2]);

        store_success = 1'b1;
        tick();
        store_success = 1'b0;
        push("pop_entries", 2); push("pop_can_store0", 0); push("pop_valid0", 0);
        push("pop_head", 1); push("pop_wenable", 0); push("pop_cache_value", 0);
        @(negedge clk);
        pop_check({29'b0, dut.entries}); pop_check({31'b0, dut.can_store[0]});
        pop_check({31'b0, dut.valid[0]}); pop_check({30'b0, dut.head});
        pop_check({31'b0, cache_wenable}); pop_check(cache_store_value);
        $display("pop: entries=%0d head=%0d wenable=%0b", dut.entries, dut.head, cache_wenable);

        rst = 1'b1;
        drive_store(32'hDEAD, 32'h40, 3'd5, 2'd2);
        tick();
        rst = 1'b0; store = 1'b0;
        push("rst2_head", 0); push("rst2_tail", 0); push("rst2_entries", 0);
        for (int i = 0; i < N; i++) begin
            push($sformatf("rst2_value%0d", i), 0);
            push($sformatf("rst2_addr%0d", i), 0);
            push($sformatf("rst2_valid%0d", i), 0);
            push($sformatf("rst2_size%0d", i), 0);
        end
        @(negedge clk);
        pop_check({30'b0, dut.head}); pop_check({30'b0, dut.tail});
        pop_check({29'b0, dut.entries});
        for (int i = 0; i < N; i++) begin
            pop_check(dut.value[i]); pop_check(dut.physical_addresses[i]);
            pop_check({31'b0, dut.valid[i]}); pop_check({30'b0, dut.size[i]});
        end
        $display("reset with store: head=%0d tail=%0d entries=%0d", dut.head, dut.tail, dut.entries);

        for (int i = 0; i < N; i++) begin
            drive_store(32'hC0DE_0000 | 32'(i), (i < 2) ? 32'd32 : 32'(32 * i), 3'(i), 2'd2);
            if (i == N - 1) begin
                push("fill_full_before_last", 0);
                @(negedge clk);
                pop_check({31'b0, full});
            end
            tick();
        end
        drive_store(32'hBB, 32'd128, 3'd4, 2'd2);
        push("fill_full", 1); push("fill_entries", N);
        @(negedge clk);
        pop_check({31'b0, full}); pop_check({29'b0, dut.entries});
        tick();
        store = 1'b0;
        push("drop_entries", N); push("drop_tail", 0); push("drop_value0", 32'hC0DE_0000);
        @(negedge clk);
        pop_check({29'b0, dut.entries}); pop_check({30'b0, dut.tail}); pop_check(dut.value[0]);
        $display("fill: full=%0b entries=%0d (extra store dropped)", full, dut.entries);

        probe("lw32_youngest", 32'd32, 2'd2, 32'hC0DE_0001, 1'b1, 1'b1);
        probe("lh34_youngest", 32'd34, 2'd1, 32'hC0DE, 1'b1, 1'b1);

        store_permission = 1'b1; store_permission_rob_id = 3'd0;
        tick();
        store_permission = 1'b0;
        drive_store(32'hBB, 32'd128, 3'd4, 2'd2);
        store_success = 1'b1;
        tick();
        store = 1'b0; store_success = 1'b0;
        push("fullpop_entries", 3); push("fullpop_head", 1); push("fullpop_tail", 0);
        @(negedge clk);
        pop_check({29'b0, dut.entries}); pop_check({30'b0, dut.head}); pop_check({30'b0, dut.tail});
        $display("pop while full: entries=%0d head=%0d tail=%0d", dut.entries, dut.head, dut.tail);

        store_permission = 1'b1; store_permission_rob_id = 3'd1;
        tick();
        store_permission = 1'b0;
        drive_store(32'hBB, 32'd128, 3'd4, 2'd2);
        store_success = 1'b1;
        push("same_cycle_alloc_unseen", 0);
        @(negedge clk);
        pop_check({31'b0, bypass_needed});
        tick();
        store = 1'b0; store_success = 1'b0;
        push("allocpop_entries", 3); push("allocpop_head", 2); push("allocpop_tail", 1);
        push("allocpop_value0", 32'hBB);
        @(negedge clk);
        pop_check({29'b0, dut.entries}); pop_check({30'b0, dut.head});
        pop_check({30'b0, dut.tail}); pop_check(dut.value[0]);
        $display("alloc+pop: entries=%0d head=%0d tail=%0d", dut.entries, dut.head, dut.tail);

        probe("lw128_wrapped", 32'd128, 2'd2, 32'hBB, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
